// File: rtl/fifo_umbral_pkg.sv
// Shared constants for the fifo_umbral queues: default geometry and the layout
// of each queue's threshold slice inside the 14-bit umbrales_I vector.
package fifo_umbral_pkg;

  localparam int FIFO_DATA_W   = 6;
  localparam int FIFO_ADDR_W   = 4;
  localparam int FIFO_UMBRAL_W = 4;

  // Threshold widths per queue
  localparam int UMB_W_MF  = 2;
  localparam int UMB_W_VC0 = 4;
  localparam int UMB_W_VC1 = 4;
  localparam int UMB_W_D0  = 2;
  localparam int UMB_W_D1  = 2;
  localparam int UMBRALES_W = UMB_W_MF + UMB_W_VC0 + UMB_W_VC1 + UMB_W_D0 + UMB_W_D1;

  // LSB offset of each slice, packed MF at bit 0 upward
  localparam int UMB_OFF_MF  = 0;
  localparam int UMB_OFF_VC0 = UMB_OFF_MF  + UMB_W_MF;
  localparam int UMB_OFF_VC1 = UMB_OFF_VC0 + UMB_W_VC0;
  localparam int UMB_OFF_D0  = UMB_OFF_VC1 + UMB_W_VC1;
  localparam int UMB_OFF_D1  = UMB_OFF_D0  + UMB_W_D0;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W storage with a synchronous write port. The read port is a
// registered 1-cycle read, or combinational when FIFO_FWFT_EN is defined.
module fifo_mem #(
  parameter int DATA_W = 6,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
`ifndef FIFO_FWFT_EN
  input  logic              rst_n,
  input  logic              re_i,
`endif
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage is intentionally left out of reset
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

`ifdef FIFO_FWFT_EN
  assign rdata_o = mem_q[raddr_i];
`else
  logic [DATA_W-1:0] rdata_q;

  // Read register holds its value when no read is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
`endif

endmodule

// File: rtl/fifo_umbral.sv
// Single-clock FIFO with programmable almost-empty/almost-full thresholds and a
// sticky overflow/underflow flag. Define FIFO_FWFT_EN for first-word-fall-through.
module fifo_umbral
  import fifo_umbral_pkg::*;
#(
  parameter int DATA_W   = FIFO_DATA_W,
  parameter int ADDR_W   = FIFO_ADDR_W,
  parameter int UMBRAL_W = FIFO_UMBRAL_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                init,
  input  logic [UMBRAL_W-1:0] umbral,
  input  logic                push,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                pop,
  output logic [DATA_W-1:0]   data_out,
  output logic                valid_out,
  output logic                fifo_empty,
  output logic                fifo_full,
  output logic                almost_empty,
  output logic                almost_full,
  output logic                fifo_error
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int SUM_W = ADDR_W + 2;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [SUM_W-1:0]  SUM_FULL  = SUM_W'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q,  count_d;
  logic [UMBRAL_W-1:0] umbral_q, umbral_d;
  logic                error_q,  error_d;
  logic                do_push, do_pop, err_set;
  logic [CNT_W-1:0]    umb_ext;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_FULL);

  // A full FIFO still accepts a push when a pop frees a slot in the same cycle
  assign do_pop  = pop  && !fifo_empty;
  assign do_push = push && (!fifo_full || pop);
  assign err_set = (push && fifo_full && !pop) || (pop && fifo_empty);

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    umbral_d = init ? umbral : umbral_q;
    // Setting wins over an init clear in the same cycle
    error_d  = err_set ? 1'b1 : (init ? 1'b0 : error_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      umbral_q <= '0;
      error_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      umbral_q <= umbral_d;
      error_q  <= error_d;
    end
  end

  assign umb_ext      = CNT_W'(umbral_q);
  assign almost_empty = (count_q <= umb_ext);
  // Widened sum avoids DEPTH - umbral_q underflow for large thresholds
  assign almost_full  = ({1'b0, count_q} + {1'b0, umb_ext}) >= SUM_FULL;
  assign fifo_error   = error_q;

  fifo_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
    .clk     (clk),
`ifndef FIFO_FWFT_EN
    .rst_n   (reset),
    .re_i    (do_pop),
`endif
    .we_i    (do_push),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (data_out)
  );

`ifdef FIFO_FWFT_EN
  assign valid_out = !fifo_empty;
`else
  logic valid_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) valid_q <= 1'b0;
    else        valid_q <= do_pop;
  end

  assign valid_out = valid_q;
`endif

endmodule

// File: doc/fifo_umbral.md
Name: fifo_umbral

Overview:
- Single-clock synchronous FIFO with programmable almost-full/almost-empty thresholds, one instance per queue (MF, VC0, VC1, D0, D1).
- Sits directly downstream of the FSM control block: takes its threshold slice from umbrales_I and is captured on init.
- Produces the per-FIFO empty and error status bits that the FSM consumes as FIFO_empty[i] and FIFO_error[i].

Parameters:
- DATA_W, 6, width of each data word.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries (default 16).
- UMBRAL_W, 4, width of the threshold input. Must be <= ADDR_W. Upper bits are zero-extended.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- init  in  1  when high, capture umbral and clear the sticky error.
- umbral  in  UMBRAL_W  threshold from the FSM control block.
- push  in  1  write request.
- data_in  in  DATA_W  write data.
- pop  in  1  read request.
- data_out  out  DATA_W  read data.
- valid_out  out  1  data_out is valid this cycle.
- fifo_empty  out  1  count == 0.
- fifo_full  out  1  count == DEPTH.
- almost_empty  out  1  count <= umbral_q.
- almost_full  out  1  count >= DEPTH - umbral_q.
- fifo_error  out  1  sticky overflow/underflow flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - wr_ptr = 0, rd_ptr = 0, count = 0, umbral_q = 0.
  - data_out = 0, valid_out = 0, fifo_error = 0.
  - fifo_empty = 1, fifo_full = 0, almost_empty = 1, almost_full = 0.
  - Memory contents are not reset.
- Reset mid-operation: all state is lost immediately, with no drain. On release, the block behaves as after power-up.
- State and width rules:
  - count is ADDR_W+1 bits, ranging 0..DEPTH.
  - Pointers are ADDR_W bits and wrap modulo DEPTH with no special case.
- Threshold capture:
  - On a clk edge with init=1, umbral_q <= umbral and fifo_error <= 0.
  - Push and pop still operate normally during init.
  - Without init, umbral_q holds its value.
- Push, with pop=0:
  - If not full: mem[wr_ptr] <= data_in, wr_ptr++, count++.
  - If full: the write is dropped and fifo_error <= 1 (overflow).
- Pop, with push=0:
  - If not empty: data_out <= mem[rd_ptr], valid_out <= 1, rd_ptr++, count--. Read latency is 1 cycle.
  - If empty: valid_out <= 0, data_out holds, fifo_error <= 1 (underflow).
- Simultaneous push and pop:
  - Not empty and not full: both occur and count is unchanged.
  - Full: both occur (the pop frees a slot) and no error is raised.
  - Empty: the push occurs, the pop is an underflow (error set, valid_out=0), and count becomes 1. There is no write-through bypass.
- No pop, or pop rejected: valid_out <= 0 the next cycle. data_out holds its last value.
- Error source conflict: if error-setting and init occur in the same cycle, the set wins (fifo_error = 1).
- Status outputs are combinational from the registered count and umbral_q, so they update the cycle after the push/pop edge.
- Edge thresholds:
  - umbral_q = 0: almost_empty == fifo_empty and almost_full == fifo_full.
  - umbral_q >= DEPTH: almost_full = 1 always.

Optional Feature:
- Macro FIFO_FWFT_EN selects first-word-fall-through mode.
- When defined:
  - data_out continuously shows mem[rd_ptr].
  - valid_out = !fifo_empty, combinational.
  - pop acknowledges the current word with no read latency.
- When undefined: the registered 1-cycle read described above.
- Status flags and error rules are identical in both modes.

Decomposition:
- Package fifo_umbral_pkg:
  - DATA_W and ADDR_W defaults.
  - Threshold width constants for MF (2), VC0/VC1 (4) and D0/D1 (2).
  - Bit offsets of each slice within the 14-bit umbrales_I vector.
- One sub-module, fifo_mem: a DEPTH x DATA_W dual-port register array with a synchronous write port, and a read port that is registered or combinational depending on FIFO_FWFT_EN.
- Pointer, count, flag and error logic stay in fifo_umbral.

Test Plan:
1. Reset=0 for 3 cycles, then 1, with push/pop idle -> fifo_empty=1, almost_empty=1, fifo_full=0, fifo_error=0, valid_out=0.
2. init=1 with umbral=3, then push 0x01..0x0D (13 words) -> almost_full rises after the 13th push (13 >= 16-3); push 3 more -> fifo_full=1 at count 16.
3. FIFO full, push 0x3F with pop=0 -> fifo_error=1, count stays 16. Then pop 16 times -> data_out = 0x01..0x0D then the 3 remaining words in order, one cycle after each pop; pointers wrap correctly.
4. Empty FIFO, pop=1 -> fifo_error=1, valid_out=0. Next cycle init=1 -> fifo_error=0. Then push+pop together on empty -> count=1, fifo_error=1.
5. Count=5, push+pop together for 10 cycles -> count stays 5, no error, and data order is preserved across the wrap.
6. Mid-stream reset=0 asynchronously while count=7 -> all outputs return to reset values immediately, without waiting for a clk edge.
